// File: rtl/cpu_pkg.sv
// Shared opcode and state definitions for the accumulator CPU core.
package cpu_pkg;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_LDA  = 4'h1;
   localparam logic [3:0] OP_ADD  = 4'h2;
   localparam logic [3:0] OP_SUB  = 4'h3;
   localparam logic [3:0] OP_STA  = 4'h4;
   localparam logic [3:0] OP_LDI  = 4'h5;
   localparam logic [3:0] OP_JMP  = 4'h6;
   localparam logic [3:0] OP_JC   = 4'h7;
   localparam logic [3:0] OP_JZ   = 4'h8;
   localparam logic [3:0] OP_JNZ  = 4'h9;
   localparam logic [3:0] OP_CALL = 4'hA;
   localparam logic [3:0] OP_RET  = 4'hB;
   localparam logic [3:0] OP_OUT  = 4'hE;
   localparam logic [3:0] OP_HLT  = 4'hF;

   typedef enum logic [1:0] {
      STATE_FETCH,
      STATE_OPERAND,
      STATE_EXEC,
      STATE_HALT
   } state_e;

   function automatic logic has_operand(input logic [3:0] op);
      return (op >= OP_LDA) && (op <= OP_CALL);
   endfunction

endpackage

// File: rtl/cpu_stack.sv
// Return-address stack; pushes when full and pops when empty are ignored.
module cpu_stack #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int SPW = $clog2(DEPTH + 1);

   logic [SPW-1:0]   sp_q;
   logic [WIDTH-1:0] mem_q [DEPTH];

   assign full  = (sp_q == SPW'(DEPTH));
   assign empty = (sp_q == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sp_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (push && !full) begin
         for (int i = 0; i < DEPTH; i++)
            if (SPW'(i) == sp_q) mem_q[i] <= din;
         sp_q <= sp_q + SPW'(1);
      end else if (pop && !empty) begin
         sp_q <= sp_q - SPW'(1);
      end
   end

   // Top of stack is the entry just below the stack pointer.
   always_comb begin
      dout = '0;
      for (int i = 0; i < DEPTH; i++)
         if (SPW'(i + 1) == sp_q) dout = mem_q[i];
   end

endmodule

// File: rtl/cpu_core.sv
// Accumulator CPU: FETCH/OPERAND/EXEC sequencer with carry/zero flags,
// hardware return stack, clock-enable and halt/fault status.
module cpu_core
   import cpu_pkg::*;
#(
   parameter int DATA_WIDTH  = 8,
   parameter int ADDR_WIDTH  = 8,
   parameter int STACK_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  mem_we,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   output logic                  halted,
   output logic                  fault,
   output logic [ADDR_WIDTH-1:0] pc
);

   state_e                state_q, state_d;
   logic [3:0]            ir_q, ir_d;
   logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d, opr_q, opr_d, out_q, out_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic                  c_q, c_d, z_q, z_d, outv_q, outv_d, fault_q, fault_d;
   logic                  push, pop, stk_full, stk_empty;
   logic [ADDR_WIDTH-1:0] stk_dout, opr_addr;
   logic [DATA_WIDTH-1:0] addend;
   logic [DATA_WIDTH:0]   sum;

   assign opr_addr = opr_q[ADDR_WIDTH-1:0];
   // SUB is A + ~B + 1, so the carry out reads as "no borrow".
   assign addend   = (ir_q == OP_SUB) ? ~mem_rdata : mem_rdata;
   assign sum      = {1'b0, a_q} + {1'b0, addend} + (DATA_WIDTH + 1)'(ir_q == OP_SUB);

   cpu_stack #(.WIDTH(ADDR_WIDTH), .DEPTH(STACK_DEPTH)) u_stack (
      .clk  (clk),
      .rst_n(reset),
      .push (push),
      .pop  (pop),
      .din  (pc_q),
      .dout (stk_dout),
      .full (stk_full),
      .empty(stk_empty)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= STATE_FETCH;
      else if (enable) state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         STATE_FETCH:   state_d = has_operand(mem_rdata[3:0]) ? STATE_OPERAND : STATE_EXEC;
         STATE_OPERAND: state_d = STATE_EXEC;
         STATE_EXEC: begin
            if ((ir_q == OP_HLT) || ((ir_q == OP_CALL) && stk_full) ||
                ((ir_q == OP_RET) && stk_empty))
               state_d = STATE_HALT;
            else
               state_d = STATE_FETCH;
         end
         default:       state_d = STATE_HALT;
      endcase
   end

   always_comb begin
      ir_d = ir_q;  a_d = a_q;  b_d = b_q;  opr_d = opr_q;  out_d = out_q;
      pc_d = pc_q;  c_d = c_q;  z_d = z_q;  fault_d = fault_q;
      outv_d = 1'b0;  push = 1'b0;  pop = 1'b0;
      mem_addr = pc_q;  mem_we = 1'b0;
      case (state_q)
         STATE_FETCH: begin
            ir_d = mem_rdata[3:0];
            pc_d = pc_q + ADDR_WIDTH'(1);
         end
         STATE_OPERAND: begin
            opr_d = mem_rdata;
            pc_d  = pc_q + ADDR_WIDTH'(1);
         end
         STATE_EXEC: begin
            mem_addr = opr_addr;
            case (ir_q)
               OP_LDA: begin a_d = mem_rdata; z_d = (mem_rdata == '0); end
               OP_ADD, OP_SUB: begin
                  b_d = mem_rdata;
                  {c_d, a_d} = sum;
                  z_d = (sum[DATA_WIDTH-1:0] == '0);
               end
               OP_STA: mem_we = enable;
               OP_LDI: begin a_d = opr_q; z_d = (opr_q == '0); end
               OP_JMP: pc_d = opr_addr;
               OP_JC:  if (c_q)  pc_d = opr_addr;
               OP_JZ:  if (z_q)  pc_d = opr_addr;
               OP_JNZ: if (!z_q) pc_d = opr_addr;
               OP_CALL: begin
                  if (stk_full) fault_d = 1'b1;
                  else begin push = enable; pc_d = opr_addr; end
               end
               OP_RET: begin
                  if (stk_empty) fault_d = 1'b1;
                  else begin pop = enable; pc_d = stk_dout; end
               end
               OP_OUT: begin out_d = a_q; outv_d = 1'b1; end
               default: ;
            endcase
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ir_q <= '0;  a_q <= '0;  b_q <= '0;  opr_q <= '0;  out_q <= '0;
         pc_q <= '0;  c_q <= 1'b0;  z_q <= 1'b0;  outv_q <= 1'b0;  fault_q <= 1'b0;
      end else if (enable) begin
         ir_q <= ir_d;  a_q <= a_d;  b_q <= b_d;  opr_q <= opr_d;  out_q <= out_d;
         pc_q <= pc_d;  c_q <= c_d;  z_q <= z_d;  outv_q <= outv_d;  fault_q <= fault_d;
      end
   end

   assign mem_wdata = a_q;
   assign out_data  = out_q;
   assign out_valid = outv_q & enable;
   assign halted    = (state_q == STATE_HALT);
   assign fault     = fault_q;
   assign pc        = pc_q;

endmodule

// File: tb/tb_cpu_core.sv
// Directed-program bench for cpu_core with a scoreboard on out_valid and mem_we.
module tb_cpu_core;

   logic       clk = 1'b0;
   logic       reset, enable;
   logic [7:0] mem_addr, mem_rdata, mem_wdata, out_data, pc;
   logic       mem_we, out_valid, halted, fault;

   logic [7:0]  mem [256];
   logic [7:0]  exp_out [$];
   logic [15:0] exp_wr [$];
   logic [15:0] wr_e;
   int vectors = 0, miscompares = 0, out_cnt = 0, we_cnt = 0, c0;

   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_addr];
   always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

   cpu_core #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .STACK_DEPTH(2)) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_wdata(mem_wdata), .mem_we(mem_we),
      .out_data(out_data), .out_valid(out_valid), .halted(halted), .fault(fault), .pc(pc)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard whenever the core presents an output or write.
   always @(negedge clk) begin
      if (out_valid) begin
         out_cnt++;
         if (exp_out.size() == 0) check("spurious_out_valid", out_valid, 0);
         else check("out_data", out_data, exp_out.pop_front());
      end
      if (mem_we) begin
         we_cnt++;
         if (exp_wr.size() == 0) check("spurious_mem_we", mem_we, 0);
         else begin
            wr_e = exp_wr.pop_front();
            check("wr_addr", mem_addr, wr_e[15:8]);
            check("wr_data", mem_wdata, wr_e[7:0]);
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
   endtask

   task automatic w(input logic [7:0] a, input logic [7:0] d);
      mem[a] = d;
   endtask

   task automatic do_reset();
      reset = 1'b0; enable = 1'b1;
      @(posedge clk); #1;
      reset = 1'b1;
   endtask

   task automatic run_until_halt(input int max, input string name);
      int n = 0;
      while (!halted && n < max) begin tick(); n++; end
      check({name, "_halted"}, halted, 1);
   endtask

   task automatic drained(input string name);
      check({name, "_out_pending"}, exp_out.size(), 0);
      check({name, "_wr_pending"}, exp_wr.size(), 0);
   endtask

   task automatic load_add();
      clear_mem();
      w(8'h00, 8'h05); w(8'h01, 8'h05); w(8'h02, 8'h02); w(8'h03, 8'h20);
      w(8'h04, 8'h0E); w(8'h05, 8'h0F); w(8'h20, 8'h03);
   endtask

   task automatic load_sta();
      clear_mem();
      w(8'h00, 8'h05); w(8'h01, 8'h5A); w(8'h02, 8'h04); w(8'h03, 8'h80); w(8'h04, 8'h0F);
   endtask

   task automatic load_stack();
      clear_mem();
      w(8'h00, 8'h05); w(8'h01, 8'h01); w(8'h02, 8'h0A); w(8'h03, 8'h10);
      w(8'h04, 8'h05); w(8'h05, 8'h05); w(8'h06, 8'h0E); w(8'h07, 8'h0F);
      w(8'h10, 8'h05); w(8'h11, 8'h02); w(8'h12, 8'h0A); w(8'h13, 8'h20);
      w(8'h14, 8'h05); w(8'h15, 8'h04); w(8'h16, 8'h0E); w(8'h17, 8'h0B);
      w(8'h20, 8'h05); w(8'h21, 8'h03); w(8'h22, 8'h0E); w(8'h23, 8'h0B);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b0; enable = 1'b1;
      clear_mem();
      #3;
      check("rst_pc", pc, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_halted", halted, 0);
      check("rst_fault", fault, 0);
      check("rst_out_data", out_data, 0);

      // LDI 5; ADD [20]=3; OUT; HLT -> 8, halted after exactly 10 cycles
      load_add(); do_reset(); exp_out.push_back(8'h08); c0 = out_cnt;
      ticks(9);
      check("add_not_halted_9", halted, 0);
      tick();
      check("add_halted_10", halted, 1);
      check("add_pulses", out_cnt - c0, 1);
      check("add_out_hold", out_data, 8'h08);
      check("add_fault", fault, 0);
      drained("add");

      // Same sum followed by JC/JZ: neither taken (C=0, Z=0)
      load_add();
      w(8'h04, 8'h07); w(8'h05, 8'h30); w(8'h06, 8'h08); w(8'h07, 8'h30);
      w(8'h08, 8'h0E); w(8'h09, 8'h0F);
      w(8'h30, 8'h05); w(8'h31, 8'hEE); w(8'h32, 8'h0E); w(8'h33, 8'h0F);
      do_reset(); exp_out.push_back(8'h08);
      run_until_halt(60, "flags");
      check("flags_pc", pc, 8'h0A);
      drained("flags");

      // 0xF0 + 0x20 carries out -> JC taken
      mem[8'h01] = 8'hF0; mem[8'h20] = 8'h20;
      do_reset(); exp_out.push_back(8'hEE);
      run_until_halt(60, "carry");
      check("carry_pc", pc, 8'h34);
      drained("carry");

      // 0x10 - 0x10: Z=1 -> JZ taken, then C=1 -> JC taken
      clear_mem();
      w(8'h00, 8'h05); w(8'h01, 8'h10); w(8'h02, 8'h03); w(8'h03, 8'h20);
      w(8'h04, 8'h08); w(8'h05, 8'h10); w(8'h06, 8'h0E); w(8'h07, 8'h0F);
      w(8'h10, 8'h0E); w(8'h11, 8'h07); w(8'h12, 8'h18); w(8'h13, 8'h0F);
      w(8'h18, 8'h05); w(8'h19, 8'h77); w(8'h1A, 8'h0E); w(8'h1B, 8'h0F);
      w(8'h20, 8'h10);
      do_reset(); exp_out.push_back(8'h00); exp_out.push_back(8'h77);
      run_until_halt(80, "subz");
      check("subz_pc", pc, 8'h1C);
      drained("subz");

      // 0x10 - 0x11 = 0xFF with borrow: JZ and JC both fall through
      clear_mem();
      w(8'h00, 8'h05); w(8'h01, 8'h10); w(8'h02, 8'h03); w(8'h03, 8'h20);
      w(8'h04, 8'h08); w(8'h05, 8'h30); w(8'h06, 8'h07); w(8'h07, 8'h30);
      w(8'h08, 8'h0E); w(8'h09, 8'h0F);
      w(8'h30, 8'h05); w(8'h31, 8'hEE); w(8'h32, 8'h0E); w(8'h33, 8'h0F);
      w(8'h20, 8'h11);
      do_reset(); exp_out.push_back(8'hFF);
      run_until_halt(80, "subb");
      check("subb_pc", pc, 8'h0A);
      drained("subb");

      // LDA 0 sets Z (JNZ falls through); LDI 0x42 clears Z (JNZ taken)
      clear_mem();
      w(8'h00, 8'h01); w(8'h01, 8'h20); w(8'h02, 8'h09); w(8'h03, 8'h30);
      w(8'h04, 8'h05); w(8'h05, 8'h42); w(8'h06, 8'h09); w(8'h07, 8'h30);
      w(8'h08, 8'h0F); w(8'h30, 8'h0E); w(8'h31, 8'h0F);
      do_reset(); exp_out.push_back(8'h42);
      run_until_halt(60, "jnz");
      check("jnz_pc", pc, 8'h32);
      drained("jnz");

      // STA 0x80 with A=0x5A: one write strobe
      load_sta(); do_reset(); exp_wr.push_back(16'h805A); c0 = we_cnt;
      run_until_halt(40, "sta");
      check("sta_strobes", we_cnt - c0, 1);
      check("sta_mem", mem[8'h80], 8'h5A);
      check("sta_pc", pc, 8'h05);
      drained("sta");

      // Nested CALL/CALL/RET/RET with a 2-deep stack
      load_stack(); do_reset();
      exp_out.push_back(8'h03); exp_out.push_back(8'h04); exp_out.push_back(8'h05);
      run_until_halt(200, "call");
      check("call_fault", fault, 0);
      check("call_pc", pc, 8'h08);
      drained("call");

      // Third nested CALL overflows
      load_stack(); w(8'h22, 8'h0A); w(8'h23, 8'h30); w(8'h30, 8'h0E); w(8'h31, 8'h0F);
      do_reset(); c0 = out_cnt;
      run_until_halt(200, "ovf");
      check("ovf_fault", fault, 1);
      check("ovf_pc", pc, 8'h24);
      check("ovf_no_out", out_cnt - c0, 0);

      // RET on an empty stack underflows
      clear_mem(); w(8'h00, 8'h0B);
      do_reset();
      run_until_halt(20, "udf");
      check("udf_fault", fault, 1);
      check("udf_pc", pc, 8'h01);

      // JMP 0xFF then fetch of NOP wraps PC to 0
      clear_mem(); w(8'h00, 8'h06); w(8'h01, 8'hFF);
      do_reset();
      ticks(3);
      check("wrap_pc_ff", pc, 8'hFF);
      tick();
      check("wrap_pc_00", pc, 8'h00);

      // enable low for 3 cycles during ADD's operand phase
      load_add(); do_reset(); exp_out.push_back(8'h08); c0 = out_cnt;
      ticks(4);
      check("en_pc_before", pc, 8'h03);
      enable = 1'b0;
      ticks(3);
      check("en_pc_frozen", pc, 8'h03);
      check("en_addr_frozen", mem_addr, 8'h03);
      enable = 1'b1;
      ticks(5);
      check("en_not_halted", halted, 0);
      tick();
      check("en_halted", halted, 1);
      check("en_pulses", out_cnt - c0, 1);
      check("en_out_data", out_data, 8'h08);
      drained("en");

      // Reset asserted during EXEC of STA abandons the write
      load_sta(); do_reset();
      ticks(5);
      check("rsta_we_exec", mem_we, 1);
      check("rsta_addr_exec", mem_addr, 8'h80);
      check("rsta_wdata_exec", mem_wdata, 8'h5A);
      reset = 1'b0;
      #1;
      check("rsta_we", mem_we, 0);
      check("rsta_addr", mem_addr, 0);
      check("rsta_pc", pc, 0);
      check("rsta_halted", halted, 0);
      check("rsta_fault", fault, 0);
      check("rsta_out_valid", out_valid, 0);
      @(posedge clk); #1;
      check("rsta_no_write", mem[8'h80], 8'h00);
      reset = 1'b1;
      exp_wr.push_back(16'h805A);
      run_until_halt(40, "rsta");
      check("rsta_mem", mem[8'h80], 8'h5A);
      drained("rsta");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/cpu_core.md
# cpu_core

Parametrised, single-clock successor to the 8-bit bus CPU. It runs the same accumulator-style program model with several changes:
- Data and address widths are configurable.
- Tristate bus and inverted-clock latching are replaced by a synchronous datapath with separate read/write memory ports.
- Adds a carry flag, conditional jumps on carry, CALL/RET through a hardware return stack, a clock-enable for single-stepping, and halt/fault status outputs in place of simulator stops.

It sits between the program/data RAM and the output display logic.

## Interface
- `DATA_WIDTH`, default 8: accumulator, B, operand and memory word width; must be ≥ 8 and ≥ `ADDR_WIDTH`.
- `ADDR_WIDTH`, default 8: PC, MAR and memory address width.
- `STACK_DEPTH`, default 4: number of return-stack entries; must be ≥ 1.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  clock-enable; when low, all state holds and strobes are forced low.
- `mem_addr`  out  ADDR_WIDTH  RAM address.
- `mem_rdata`  in  DATA_WIDTH  RAM read data, combinational from `mem_addr`, sampled same cycle.
- `mem_wdata`  out  DATA_WIDTH  RAM write data (accumulator).
- `mem_we`  out  1  RAM write strobe, one cycle.
- `out_data`  out  DATA_WIDTH  output register.
- `out_valid`  out  1  one-cycle pulse when `out_data` updates.
- `halted`  out  1  core stopped (HLT or fault).
- `fault`  out  1  stack overflow/underflow occurred.
- `pc`  out  ADDR_WIDTH  program counter, for debug.

## Operation
- **Instruction word:** opcode = `instr[3:0]`; upper bits are ignored.
- **Operand-bearing opcodes:** the following word is the operand. For address operands, the low `ADDR_WIDTH` bits are used.
- **Opcodes:**
  - 0 NOP
  - 1 LDA a: A←M[a]
  - 2 ADD a: B←M[a], A←A+B
  - 3 SUB a: B←M[a], A←A−B
  - 4 STA a: M[a]←A
  - 5 LDI k: A←k
  - 6 JMP a
  - 7 JC a
  - 8 JZ a
  - 9 JNZ a
  - A CALL a
  - B RET
  - C–D NOP
  - E OUT: out_data←A
  - F HLT
- **States:**
  - FETCH: mem_addr=PC, IR←rdata, PC++.
  - Then → OPERAND for opcodes 1–A; → EXEC for all others.
  - OPERAND: mem_addr=PC, OPR←rdata, PC++ → EXEC.
  - EXEC: perform the opcode → FETCH. HLT or a fault → HALT instead.
  - HALT: terminal; only reset leaves it.
- **Arithmetic:**
  - ADD: {C,A} ← A+B, computed at DATA_WIDTH+1 bits.
  - SUB: computed as A+~B+1; C=1 means no borrow.
  - Z←(new A==0). Z is updated by LDA, LDI, ADD and SUB only; C is updated by ADD and SUB only.
- **Jumps:** a taken jump loads PC←OPR. A not-taken jump leaves PC already pointing past the operand.
- **CALL:** push the return address (PC after the operand), then PC←OPR.
- **RET:** PC←pop.
- **Stack faults:**
  - CALL with the stack full: no push; fault←1, → HALT.
  - RET with the stack empty: no pop; fault←1, → HALT.
- **PC wrap-around:** PC wraps from 2^ADDR_WIDTH−1 to 0 on increment, with no flag.
- **Reset:** asserting `reset` at any time clears all state asynchronously, including mid-instruction; any pending write or jump is abandoned.

## Timing
- **Reset values:** A, B, IR, OPR, PC, SP, C, Z, out_data are 0; state=FETCH. mem_we=0, out_valid=0, halted=0, fault=0. mem_addr=0 (follows PC in FETCH).
- **Latency, counted in enabled cycles:**
  - 2 cycles: NOP, OUT, RET, HLT, and opcodes C/D.
  - 3 cycles: all operand opcodes.
- **Memory writes:** `mem_we` is high only in EXEC of STA, with mem_addr=OPR and mem_wdata=A.
- **Output:** `out_valid` is high in the cycle after EXEC of OUT, coincident with the new out_data.
- **`enable` low:** freezes state, registers and PC. mem_we and out_valid are forced low; mem_addr holds.
- **HALT:** halted=1 from the cycle after the EXEC of HLT (or of the faulting CALL/RET). mem_we=0 throughout.

## Structure
- Package `cpu_pkg`:
  - opcode localparams `OP_*`
  - state enum/localparams `STATE_FETCH`, `STATE_OPERAND`, `STATE_EXEC`, `STATE_HALT`
- Sub-module `cpu_stack`:
  - parameters `WIDTH`, `DEPTH`
  - inputs push, pop, din
  - outputs dout, full, empty
  - async active-low reset
  - push is ignored when full; pop is ignored when empty

## Test plan
- LDI 5; ADD [x] with M[x]=3; OUT; HLT → out_data=8 with a single out_valid pulse; C=0, Z=0; halted after 10 enabled cycles.
- LDI 0x10; SUB [x] with M[x]=0x10; JZ L → taken, Z=1, C=1. Repeat with M[x]=0x11 → A=0xFF, C=0, Z=0, JZ not taken.
- STA 0x80 with A=0x5A → exactly one mem_we cycle, with mem_addr=0x80 and mem_wdata=0x5A.
- STACK_DEPTH=2: nested CALL, CALL, RET, RET → returns to the correct addresses. A third nested CALL → fault=1, halted=1, PC unchanged.
- PC at 0xFF executing NOP → PC=0x00 next. Toggle `enable` low for 3 cycles mid-ADD → result identical, no extra strobes.
- Assert `reset` during EXEC of STA → mem_we deasserts immediately and all outputs reach their reset values; after release, execution restarts from address 0.
